// File: rtl/aes_core_ctrl_if.sv
// aes_core_ctrl_if: host command/status and sub-block handshake bundle for the AES core sequencer
//   slave  (controller view) in : init, next, encdec, key_ready, enc_ready, dec_ready
//                            out: ready, key_valid, result_valid, error, key_init, enc_next,
//                                 dec_next, sbox_sel[1:0], enc_sel, result_we
//   master (host/sub-block view): same signals, opposite directions
interface aes_core_ctrl_if;
   logic       init, next, encdec, key_ready, enc_ready, dec_ready;
   logic       ready, key_valid, result_valid, error, key_init, enc_next, dec_next, enc_sel, result_we;
   logic [1:0] sbox_sel;
   modport slave (
      input  init, next, encdec, key_ready, enc_ready, dec_ready,
      output ready, key_valid, result_valid, error, key_init, enc_next, dec_next, sbox_sel, enc_sel, result_we
   );
   modport master (
      output init, next, encdec, key_ready, enc_ready, dec_ready,
      input  ready, key_valid, result_valid, error, key_init, enc_next, dec_next, sbox_sel, enc_sel, result_we
   );
endinterface

// File: rtl/aes_core_ctrl.sv
// aes_core_ctrl: AES core sequencer; issues key/encipher/decipher start pulses, owns S-box mux and result write
//   clk    in  clock, posedge
//   reset  in  asynchronous active-high reset
//   bus    aes_core_ctrl_if.slave (host commands, status flags, sub-block start/ready, sbox_sel, enc_sel, result_we)
//   Optional AES_CORE_CTRL_TIMEOUT_EN: adds parameter TIMEOUT_CYCLES (default 64) and an 8-bit WAIT
//   watchdog that aborts to IDLE with sticky error; without it error stays 0 and WAIT states never time out.
module aes_core_ctrl (
   input logic            clk,
   input logic            reset,
   aes_core_ctrl_if.slave bus
);
`ifdef AES_CORE_CTRL_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYCLES = 64;
   logic [7:0] wait_cnt;
   logic       timeout;
   assign timeout = wait_cnt == 8'(TIMEOUT_CYCLES - 1);
`endif
   typedef enum logic [2:0] {IDLE, INIT_START, INIT_WAIT, NEXT_START, NEXT_WAIT} state_t;
   state_t state;
   logic   done;
   // sub-block done as seen from the current WAIT state
   assign done = (state == INIT_WAIT) ? bus.key_ready : bus.enc_sel ? bus.enc_ready : bus.dec_ready;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         bus.ready        <= 1'b1;
         bus.key_valid    <= 1'b0;
         bus.result_valid <= 1'b0;
         bus.error        <= 1'b0;
         bus.key_init     <= 1'b0;
         bus.enc_next     <= 1'b0;
         bus.dec_next     <= 1'b0;
         bus.result_we    <= 1'b0;
         bus.sbox_sel     <= 2'd0;
         bus.enc_sel      <= 1'b0;
`ifdef AES_CORE_CTRL_TIMEOUT_EN
         wait_cnt         <= 8'd0;
`endif
      end else begin
         bus.key_init  <= 1'b0;
         bus.enc_next  <= 1'b0;
         bus.dec_next  <= 1'b0;
         bus.result_we <= 1'b0;
         case (state)
            IDLE:
               if (bus.init) begin
                  state            <= INIT_START;
                  bus.ready        <= 1'b0;
                  bus.key_valid    <= 1'b0;
                  bus.result_valid <= 1'b0;
                  bus.error        <= 1'b0;
                  bus.key_init     <= 1'b1;
                  bus.sbox_sel     <= 2'd1;
               end else if (bus.next && bus.key_valid) begin
                  state            <= NEXT_START;
                  bus.ready        <= 1'b0;
                  bus.result_valid <= 1'b0;
                  bus.enc_sel      <= bus.encdec;
                  bus.enc_next     <= bus.encdec;
                  bus.dec_next     <= !bus.encdec;
                  // decipher has its own S-boxes, so the shared one is only lent to encipher
                  bus.sbox_sel     <= bus.encdec ? 2'd2 : 2'd0;
               end
            INIT_START, NEXT_START: begin
               state <= (state == INIT_START) ? INIT_WAIT : NEXT_WAIT;
`ifdef AES_CORE_CTRL_TIMEOUT_EN
               wait_cnt <= 8'd0;
`endif
            end
            INIT_WAIT, NEXT_WAIT:
               if (done) begin
                  state        <= IDLE;
                  bus.ready    <= 1'b1;
                  bus.sbox_sel <= 2'd0;
                  if (state == INIT_WAIT) bus.key_valid <= 1'b1;
                  else begin
                     bus.result_valid <= 1'b1;
                     bus.result_we    <= 1'b1;
                  end
               end
`ifdef AES_CORE_CTRL_TIMEOUT_EN
               else if (timeout) begin
                  state        <= IDLE;
                  bus.ready    <= 1'b1;
                  bus.sbox_sel <= 2'd0;
                  bus.error    <= 1'b1;
               end else wait_cnt <= wait_cnt + 8'd1;
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_core_ctrl.sv
// tb_aes_core_ctrl: directed + randomized check of aes_core_ctrl against a latency-based transaction model
module tb_aes_core_ctrl;
`ifdef AES_CORE_CTRL_TIMEOUT_EN
   localparam int TC = 16;
   localparam int LAT4 = 10;
`else
   localparam int LAT4 = 50;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   aes_core_ctrl_if bus ();
`ifdef AES_CORE_CTRL_TIMEOUT_EN
   aes_core_ctrl #(.TIMEOUT_CYCLES(TC)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
   aes_core_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
`endif
   int checks = 0, failures = 0;
   int lat = 0;
   logic p_k = 1'b0, p_e = 1'b0, p_d = 1'b0;
   logic kr = 1'b1, er = 1'b1, dr = 1'b1;
   int rem_k = 0, rem_e = 0, rem_d = 0;
   assign bus.key_ready = kr;
   assign bus.enc_ready = er;
   assign bus.dec_ready = dr;
   // sub-block stubs: busy for `lat` cycles after their start pulse, then ready
   always @(posedge clk) begin
      if (p_k) begin rem_k <= lat; kr <= (lat == 0); end
      else if (rem_k > 0) begin rem_k <= rem_k - 1; kr <= (rem_k == 1); end
      if (p_e) begin rem_e <= lat; er <= (lat == 0); end
      else if (rem_e > 0) begin rem_e <= rem_e - 1; er <= (rem_e == 1); end
      if (p_d) begin rem_d <= lat; dr <= (lat == 0); end
      else if (rem_d > 0) begin rem_d <= rem_d - 1; dr <= (rem_d == 1); end
   end
   // transaction model: op 0=idle 1=init 2=next; age counts cycles since accept.
   // A sub-block busy for n cycles finishes the op in its (n+2)th cycle.
   int m_op = 0, m_age = 0, m_n = 0;
   bit m_kv = 0, m_rv = 0, m_err = 0, m_es = 0, m_we = 0;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_op <= 0; m_age <= 0; m_kv <= 0; m_rv <= 0; m_err <= 0; m_es <= 0; m_we <= 0;
      end else begin
         m_we <= 0;
         if (m_op == 0) begin
            if (bus.init) begin m_op <= 1; m_age <= 1; m_kv <= 0; m_rv <= 0; m_err <= 0; end
            else if (bus.next && m_kv) begin m_op <= 2; m_age <= 1; m_rv <= 0; m_es <= bus.encdec; end
         end else if (m_age == 1) begin m_n <= lat; m_age <= 2; end
         else if (m_age == m_n + 2) begin
            if (m_op == 1) m_kv <= 1;
            else begin m_rv <= 1; m_we <= 1; end
            m_op <= 0;
         end
`ifdef AES_CORE_CTRL_TIMEOUT_EN
         else if (m_age == TC + 1) begin m_err <= 1; m_op <= 0; end
`endif
         else m_age <= m_age + 1;
      end
   end
   int n_ki, n_en, n_dn, n_we, n_s1, n_s2;
   task automatic clr;
      n_ki = 0; n_en = 0; n_dn = 0; n_we = 0; n_s1 = 0; n_s2 = 0;
   endtask
   task automatic step;
      logic [10:0] act, exp;
      @(negedge clk);
      act = {bus.ready, bus.key_valid, bus.result_valid, bus.error, bus.key_init, bus.enc_next,
             bus.dec_next, bus.sbox_sel, bus.enc_sel, bus.result_we};
      exp = {m_op == 0, m_kv, m_rv, m_err, m_op == 1 && m_age == 1, m_op == 2 && m_age == 1 && m_es,
             m_op == 2 && m_age == 1 && !m_es,
             (m_op == 1) ? 2'd1 : (m_op == 2 && m_es) ? 2'd2 : 2'd0, m_es, m_we};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL model t=%0t got=%b want=%b (rdy kv rv err ki en dn sbox2 es we)", $time, act, exp);
      end
      p_k = bus.key_init; p_e = bus.enc_next; p_d = bus.dec_next;
      n_ki += int'(bus.key_init); n_en += int'(bus.enc_next); n_dn += int'(bus.dec_next);
      n_we += int'(bus.result_we); n_s1 += int'(bus.sbox_sel == 2'd1); n_s2 += int'(bus.sbox_sel == 2'd2);
      #1;
   endtask
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask
   // call with init/next already driven; returns cycles spent with ready low
   task automatic run_op(input bit hold, output int busy);
      busy = 0;
      step;
      if (!hold) begin bus.init = 0; bus.next = 0; end
      while (!bus.ready && busy < 200) begin busy++; step; end
      if (!bus.ready) begin failures++; $display("FAIL op_timeout got=busy want=ready"); end
      bus.init = 0; bus.next = 0;
   endtask
   int busy;
   initial begin
      bus.init = 0; bus.next = 0; bus.encdec = 0;
      repeat (2) step;
      reset = 0;
      step;
      chk("rst_ready", int'(bus.ready), 1);
      chk("rst_key_valid", int'(bus.key_valid), 0);
      chk("rst_result_valid", int'(bus.result_valid), 0);
      chk("rst_sbox", int'(bus.sbox_sel), 0);
      // next before any init is ignored
      clr; bus.next = 1; bus.encdec = 1;
      repeat (4) step;
      bus.next = 0;
      chk("nokey_ready", int'(bus.ready), 1);
      chk("nokey_pulses", n_en + n_dn, 0);
      chk("nokey_rv", int'(bus.result_valid), 0);
      // init and next together: init wins
      clr; lat = 11; bus.init = 1; bus.next = 1;
      run_op(0, busy);
      chk("init_busy", busy, 13);
      chk("init_key_init", n_ki, 1);
      chk("init_sbox1", n_s1, 13);
      chk("init_no_next", n_en + n_dn, 0);
      chk("init_kv", int'(bus.key_valid), 1);
      chk("init_sbox_end", int'(bus.sbox_sel), 0);
      // encipher
      clr; lat = LAT4; bus.next = 1; bus.encdec = 1;
      run_op(0, busy);
      chk("enc_busy", busy, LAT4 + 2);
      chk("enc_next", n_en, 1);
      chk("enc_no_dec", n_dn, 0);
      chk("enc_sbox2", n_s2, LAT4 + 2);
      chk("enc_we", n_we, 1);
      chk("enc_rv", int'(bus.result_valid), 1);
      chk("enc_sel", int'(bus.enc_sel), 1);
      chk("enc_kv", int'(bus.key_valid), 1);
      // decipher with next held while busy
      clr; lat = 5; bus.next = 1; bus.encdec = 0;
      run_op(1, busy);
      chk("dec_busy", busy, 7);
      chk("dec_next", n_dn, 1);
      chk("dec_no_enc", n_en, 0);
      chk("dec_sbox2", n_s2, 0);
      chk("dec_we", n_we, 1);
      chk("dec_sel", int'(bus.enc_sel), 0);
      // reset in the middle of INIT_WAIT
      clr; lat = 20; bus.init = 1;
      step;
      bus.init = 0;
      repeat (5) step;
      reset = 1;
      step;
      chk("midrst_ready", int'(bus.ready), 1);
      chk("midrst_kv", int'(bus.key_valid), 0);
      chk("midrst_sbox", int'(bus.sbox_sel), 0);
      chk("midrst_pulses", int'(bus.key_init) + int'(bus.enc_next) + int'(bus.dec_next), 0);
      reset = 0;
      step;
`ifdef AES_CORE_CTRL_TIMEOUT_EN
      clr; lat = 30; bus.init = 1;
      run_op(0, busy);
      chk("to_init_busy", busy, TC + 1);
      chk("to_init_err", int'(bus.error), 1);
      chk("to_init_kv", int'(bus.key_valid), 0);
      clr; lat = 3; bus.init = 1;
      step;
      chk("to_err_clear", int'(bus.error), 0);
      bus.init = 0;
      while (!bus.ready) step;
      clr; lat = 40; bus.next = 1; bus.encdec = 1;
      run_op(0, busy);
      chk("to_next_busy", busy, TC + 1);
      chk("to_next_err", int'(bus.error), 1);
      chk("to_next_we", n_we, 0);
      chk("to_next_rv", int'(bus.result_valid), 0);
`endif
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         bus.init = ($urandom_range(0, 19) == 0);
         bus.next = ($urandom_range(0, 2) == 0);
         bus.encdec = 1'($urandom_range(0, 1));
         lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 12));
         step;
      end
      reset = 0; bus.init = 0; bus.next = 0;
      repeat (3) step;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
